// File: rtl/tpu_instr_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_tpu
//  Description : Shared types and sizing constants for the multi-thread
//                TPU instruction memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_tpu;

    localparam int INSTR_WIDTH     = 64;
    localparam int DEPTH           = 1024;
    localparam int SIZE_THREAD_MEM = DEPTH;
    localparam int NUM_THREADS     = 4;
    localparam int TID_W           = $clog2(NUM_THREADS);
    localparam int AW              = $clog2(DEPTH / NUM_THREADS);

    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [AW-1:0]          t_address_t;
    typedef logic [TID_W-1:0]       tid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } imem_st_state_t;

endpackage : pkg_tpu
`default_nettype wire

// File: rtl/tpu_instr_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_instr_mem_ctrl_if
//  Description : Store-burst handshake, load port and loaded flags of the
//                TPU instruction memory. Parity signals exist only when
//                TPU_IMEM_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tpu_instr_mem_ctrl_if;
    import pkg_tpu::*;

    logic                   I_St_Start;
    tid_t                   I_St_Thread;
    t_address_t             I_St_Base;
    t_address_t             I_St_Len;
    logic                   I_St_Valid;
    logic                   O_St_Ready;
    instr_t                 I_St_Instr;
    logic                   O_St_Done;
    logic                   O_St_Busy;
    logic                   I_Req_Ld;
    tid_t                   I_Ld_Thread;
    t_address_t             I_Ld_Address;
    logic                   O_Ld_Valid;
    instr_t                 O_Ld_Instr;
    logic [NUM_THREADS-1:0] O_Loaded;
`ifdef TPU_IMEM_PARITY_EN
    logic                   O_Ld_Err;
    logic                   I_Inj_Err;
`endif

    // Dispatcher / fetch side
    modport master (
        output I_St_Start, I_St_Thread, I_St_Base, I_St_Len, I_St_Valid,
        output I_St_Instr, I_Req_Ld, I_Ld_Thread, I_Ld_Address,
`ifdef TPU_IMEM_PARITY_EN
        output I_Inj_Err,
        input  O_Ld_Err,
`endif
        input  O_St_Ready, O_St_Done, O_St_Busy, O_Ld_Valid, O_Ld_Instr,
        input  O_Loaded
    );

    // Memory controller side
    modport slave (
        input  I_St_Start, I_St_Thread, I_St_Base, I_St_Len, I_St_Valid,
        input  I_St_Instr, I_Req_Ld, I_Ld_Thread, I_Ld_Address,
`ifdef TPU_IMEM_PARITY_EN
        input  I_Inj_Err,
        output O_Ld_Err,
`endif
        output O_St_Ready, O_St_Done, O_St_Busy, O_Ld_Valid, O_Ld_Instr,
        output O_Loaded
    );

endinterface : tpu_instr_mem_ctrl_if
`default_nettype wire

// File: rtl/tpu_instr_mem_ctrl_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_imem_ram
//  Description : Simple dual-port array, one write and one registered read
//                port, read-first on address collision. With
//                TPU_IMEM_PARITY_EN each word carries an even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_imem_ram #(
    parameter int WIDTH  = 64,
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 10
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [WIDTH-1:0]  wr_data,
`ifdef TPU_IMEM_PARITY_EN
    input  wire logic              wr_inj_err,
    output logic                   rd_err,
`endif
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data
);

`ifdef TPU_IMEM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    logic [MEM_W-1:0] r_mem [WORDS];

    // Write port; the array itself is never reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
`ifdef TPU_IMEM_PARITY_EN
            r_mem[wr_addr] <= {(^wr_data) ^ wr_inj_err, wr_data};
`else
            r_mem[wr_addr] <= wr_data;
`endif
        end
    end

    // Registered read; nonblocking semantics give read-first on collision
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef TPU_IMEM_PARITY_EN
            rd_err   <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= r_mem[rd_addr][WIDTH-1:0];
            end
`ifdef TPU_IMEM_PARITY_EN
            rd_err <= rd_en & (^r_mem[rd_addr]);
`endif
        end
    end

endmodule : tpu_imem_ram
`default_nettype wire

// File: rtl/tpu_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_instr_mem_ctrl
//  Description : Multi-thread instruction memory. Store-burst FSM with
//                valid/ready handshake, 1-cycle load port, per-thread
//                program-loaded flags. Optional parity: TPU_IMEM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tpu_instr_mem_ctrl
    import pkg_tpu::*;
(
    input  wire logic            clock,
    input  wire logic            reset,
    tpu_instr_mem_ctrl_if.slave  bus
);

    imem_st_state_t         r_state;
    tid_t                   r_thread;
    t_address_t             r_addr;
    t_address_t             r_remain;
    logic                   r_st_ready;
    logic                   r_st_busy;
    logic                   r_st_done;
    logic [NUM_THREADS-1:0] r_loaded;

    logic                   w_beat;

    assign w_beat = (r_state == BURST) && bus.I_St_Valid && r_st_ready;

    // Store-burst FSM; all handshake outputs are registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_thread   <= '0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_st_ready <= 1'b0;
            r_st_busy  <= 1'b0;
            r_st_done  <= 1'b0;
            r_loaded   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_st_done <= 1'b0;
                    if (bus.I_St_Start) begin
                        r_thread                  <= bus.I_St_Thread;
                        r_addr                    <= bus.I_St_Base;
                        r_remain                  <= bus.I_St_Len;
                        r_loaded[bus.I_St_Thread] <= 1'b0;
                        r_st_ready                <= 1'b1;
                        r_st_busy                 <= 1'b1;
                        r_state                   <= BURST;
                    end
                end
                BURST: begin
                    if (w_beat) begin
                        // Address wraps inside the region of r_thread
                        r_addr   <= r_addr + t_address_t'(1);
                        r_remain <= r_remain - t_address_t'(1);
                        if (r_remain == '0) begin
                            r_st_ready         <= 1'b0;
                            r_st_busy          <= 1'b0;
                            r_st_done          <= 1'b1;
                            r_loaded[r_thread] <= 1'b1;
                            r_state            <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_st_done <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_st_ready <= 1'b0;
                    r_st_busy  <= 1'b0;
                    r_st_done  <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.O_St_Ready = r_st_ready;
    assign bus.O_St_Busy  = r_st_busy;
    assign bus.O_St_Done  = r_st_done;
    assign bus.O_Loaded   = r_loaded;

    tpu_imem_ram #(
        .WIDTH  (INSTR_WIDTH),
        .WORDS  (SIZE_THREAD_MEM),
        .ADDR_W (TID_W + AW)
    ) u_ram (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (w_beat),
        .wr_addr    ({r_thread, r_addr}),
        .wr_data    (bus.I_St_Instr),
`ifdef TPU_IMEM_PARITY_EN
        .wr_inj_err (bus.I_Inj_Err),
        .rd_err     (bus.O_Ld_Err),
`endif
        .rd_en      (bus.I_Req_Ld),
        .rd_addr    ({bus.I_Ld_Thread, bus.I_Ld_Address}),
        .rd_valid   (bus.O_Ld_Valid),
        .rd_data    (bus.O_Ld_Instr)
    );

endmodule : tpu_instr_mem_ctrl
`default_nettype wire

// File: doc/tpu_instr_mem_ctrl.md
Name: tpu_instr_mem_ctrl

Overview:
Multi-thread instruction memory for the TPU scalar unit, the successor to the single-port InstrMem. It is partitioned into NUM_THREADS equal regions.
- Store side: burst FSM with a valid/ready handshake, fed by the MPU dispatcher, with a completion pulse.
- Load side: registered read port with a valid strobe, feeding scalar-unit instruction fetch.
- Per-thread "program loaded" flags gate thread launch.

Parameters:
INSTR_WIDTH, 64, instruction word width (instr_t).
DEPTH, 1024, total words; must be a multiple of NUM_THREADS.
NUM_THREADS, 4, number of regions/threads; power of two.
TID_W, $clog2(NUM_THREADS), thread-id width.
AW, $clog2(DEPTH/NUM_THREADS), in-region address width.

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
I_St_Start  in  1  pulse: begin store burst
I_St_Thread  in  TID_W  target thread region
I_St_Base  in  AW  first in-region word address
I_St_Len  in  AW  beat count minus one
I_St_Valid  in  1  store beat valid
O_St_Ready  out  1  store beat accepted when Valid&&Ready
I_St_Instr  in  INSTR_WIDTH  store data
O_St_Done  out  1  one-cycle pulse after last beat written
O_St_Busy  out  1  burst in progress
I_Req_Ld  in  1  load request
I_Ld_Thread  in  TID_W  load thread region
I_Ld_Address  in  AW  load in-region address
O_Ld_Valid  out  1  load data valid
O_Ld_Instr  out  INSTR_WIDTH  loaded instruction
O_Loaded  out  NUM_THREADS  per-thread program-loaded flags

Behaviour:
- Reset values: O_St_Ready=0, O_St_Done=0, O_St_Busy=0, O_Ld_Valid=0, O_Ld_Instr=0, O_Loaded=0, FSM=IDLE. Memory array is not reset.
- Physical address = {thread, in-region addr}.
- FSM states:
  - IDLE: I_St_Start latches thread, base as the address counter, and Len as the remaining counter, then goes to BURST. O_Loaded[thread] clears in the same cycle.
  - BURST: O_St_Ready=1 and O_St_Busy=1. Each Valid&&Ready beat writes I_St_Instr to the current address. The address increments modulo 2^AW, wrapping inside the region and never crossing into another thread. The remaining counter decrements. A beat with remaining==0 moves to DONE.
  - DONE: one cycle only. O_St_Done=1, O_Loaded[thread] sets, O_St_Ready=0, then back to IDLE.
- Burst boundary conditions:
  - I_St_Start outside IDLE is ignored, with no side effects.
  - Valid low inside BURST stalls the burst; there is no timeout.
  - Valid outside BURST is not accepted and writes nothing.
  - Length: Len=0 means 1 beat; Len=2^AW-1 means the full region.
- Load timing: latency 1. If I_Req_Ld is high in cycle N, then in cycle N+1 O_Ld_Valid=1 and O_Ld_Instr=mem[addr].
- Load hold rules:
  - With no request, O_Ld_Valid=0 and O_Ld_Instr holds its last value.
  - Loads are always accepted, including to a thread under store, and back-to-back loads give one result per cycle.
- Simultaneous load and store to the same physical address: read-first. The load returns the old word and the write completes that cycle.
- Reset mid-burst:
  - FSM returns to IDLE and all O_Loaded bits clear.
  - Partially written words remain in the array.
  - A pending load valid is dropped.

Optional Feature:
Macro TPU_IMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed at write time.
  - Extra port O_Ld_Err (out, 1) is asserted alongside O_Ld_Valid when the recomputed parity mismatches; its reset value is 0.
  - The bench hook input I_Inj_Err (in, 1) flips the stored parity bit on the current write beat.
- Undefined: the array is INSTR_WIDTH wide, and neither O_Ld_Err nor I_Inj_Err exists.

Decomposition:
- pkg_tpu holds:
  - instr_t;
  - the constants SIZE_THREAD_MEM (=DEPTH) and NUM_THREADS;
  - the typedef t_address_t (AW bits);
  - the typedef tid_t;
  - the enum imem_st_state_t {IDLE, BURST, DONE}.
- One natural sub-module, tpu_imem_ram: a simple dual-port array with registered read, read-first behaviour, and an optional parity lane. The controller, FSM and flags stay in the top level.

Test Plan:
- Reset, then Start thread 2, base 0, Len 3, with 4 beats 0xA0..0xA3 and Valid held high:
  - Ready high for 4 cycles and Done pulses once;
  - O_Loaded=4'b0100;
  - loads of thread 2 addr 0..3 return 0xA0..0xA3, each with Valid one cycle after its request.
- Wrap: thread 1, base 2^AW-2, Len 3. Words land at in-region addresses 2^AW-2, 2^AW-1, 0 and 1 of thread 1, and threads 0 and 2 are unchanged.
- Stall: Valid toggled 1,0,0,1,1 during a Len=2 burst. Exactly 3 writes occur, Done comes one cycle after the third accepted beat, and a second Start during BURST is ignored.
- Collision:
  - mem[t0,5]=0x11, then load and store 0x22 to t0,5 in the same cycle;
  - load returns 0x11;
  - next load returns 0x22.
- Reset asserted mid-burst after 2 of 4 beats: Busy=0, Ready=0, O_Loaded=0, Ld_Valid=0 the following cycle, and a new burst starts normally.
- With TPU_IMEM_PARITY_EN, write with I_Inj_Err=1 at t3,7: the load of t3,7 gives O_Ld_Err=1 with Valid, and loads of other words give Err=0.
